// File: rtl/alu_cmd_pkg.sv
// rtl/alu_cmd_pkg.sv - sequencer state type, frame start marker and ALU function codes
package alu_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUN,
    ST_ALU_GO,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_t;

  localparam logic [7:0] CMD_BYTE_DEFAULT = 8'hCC;

  // Function codes shared with the ALU; 4'b1111 is unused and yields zero.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NAND = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_XNOR = 4'b1001;
  localparam logic [3:0] ALU_EQ   = 4'b1010;
  localparam logic [3:0] ALU_GT   = 4'b1011;
  localparam logic [3:0] ALU_LT   = 4'b1100;
  localparam logic [3:0] ALU_SHR  = 4'b1101;
  localparam logic [3:0] ALU_SHL  = 4'b1110;

endpackage

// File: rtl/alu_cmd_timer.sv
// rtl/alu_cmd_timer.sv - partial-frame idle counter, used only when ALU_CMD_TIMEOUT_EN is defined
module alu_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || !run || clear) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // A byte arriving in the expiry cycle takes priority over the abort.
  assign expired = run && !clear && (count == LAST);

endmodule

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - UART frame to ALU command sequencer with two-byte result return
// Optional partial-frame abort enabled by defining ALU_CMD_TIMEOUT_EN.
module alu_cmd_ctrl
  import alu_cmd_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ALU_FUN_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_BYTE       = DATA_WIDTH'(CMD_BYTE_DEFAULT),
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic [DATA_WIDTH-1:0]     i_RX_DATA,
  input  logic                      i_RX_VALID,
  output logic [DATA_WIDTH-1:0]     o_ALU_A,
  output logic [DATA_WIDTH-1:0]     o_ALU_B,
  output logic [ALU_FUN_WIDTH-1:0]  o_ALU_FUN,
  output logic                      o_ALU_EN,
  input  logic [2*DATA_WIDTH-1:0]   i_ALU_OUT,
  input  logic                      i_ALU_VALID,
  output logic [DATA_WIDTH-1:0]     o_TX_DATA,
  output logic                      o_TX_VALID,
  input  logic                      i_TX_READY,
  output logic                      o_BUSY,
  output logic                      o_RX_DROP
);

  state_t                state;
  logic [DATA_WIDTH-1:0] result_hi;
  logic                  timer_expired;
  logic                  in_frame;
  logic                  in_backend;

  assign in_frame   = (state == ST_GET_A) || (state == ST_GET_B) || (state == ST_GET_FUN);
  assign in_backend = (state == ST_ALU_GO) || (state == ST_ALU_WAIT) ||
                      (state == ST_TX_LO) || (state == ST_TX_HI);
  assign o_BUSY     = (state != ST_IDLE);

`ifdef ALU_CMD_TIMEOUT_EN
  alu_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (i_CLK),
    .rst    (i_RST),
    .run    (in_frame),
    .clear  (i_RX_VALID),
    .expired(timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state      <= ST_IDLE;
      result_hi  <= '0;
      o_ALU_A    <= '0;
      o_ALU_B    <= '0;
      o_ALU_FUN  <= '0;
      o_ALU_EN   <= 1'b0;
      o_TX_DATA  <= '0;
      o_TX_VALID <= 1'b0;
      o_RX_DROP  <= 1'b0;
    end else begin
      o_ALU_EN  <= 1'b0;
      o_RX_DROP <= i_RX_VALID && in_backend;
      case (state)
        ST_IDLE: begin
          if (i_RX_VALID && (i_RX_DATA == CMD_BYTE)) state <= ST_GET_A;
        end
        ST_GET_A: begin
          if (i_RX_VALID) begin
            o_ALU_A <= i_RX_DATA;
            state   <= ST_GET_B;
          end else if (timer_expired) begin
            state <= ST_IDLE;
          end
        end
        ST_GET_B: begin
          if (i_RX_VALID) begin
            o_ALU_B <= i_RX_DATA;
            state   <= ST_GET_FUN;
          end else if (timer_expired) begin
            state <= ST_IDLE;
          end
        end
        ST_GET_FUN: begin
          if (i_RX_VALID) begin
            o_ALU_FUN <= i_RX_DATA[ALU_FUN_WIDTH-1:0];
            o_ALU_EN  <= 1'b1;
            state     <= ST_ALU_GO;
          end else if (timer_expired) begin
            state <= ST_IDLE;
          end
        end
        ST_ALU_GO: state <= ST_ALU_WAIT;
        ST_ALU_WAIT: begin
          // The ALU clears its output after the enable drops, so only the valid cycle is usable.
          if (i_ALU_VALID) begin
            result_hi  <= i_ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
            o_TX_DATA  <= i_ALU_OUT[DATA_WIDTH-1:0];
            o_TX_VALID <= 1'b1;
            state      <= ST_TX_LO;
          end
        end
        ST_TX_LO: begin
          if (i_TX_READY) begin
            o_TX_DATA <= result_hi;
            state     <= ST_TX_HI;
          end
        end
        ST_TX_HI: begin
          if (i_TX_READY) begin
            o_TX_VALID <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - self-checking bench for alu_cmd_ctrl with a behavioural ALU and result model
module tb_alu_cmd_ctrl;
  import alu_cmd_pkg::*;

  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out = '0;
  logic        alu_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        rx_drop;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  alu_cmd_ctrl #(
    .DATA_WIDTH(8), .ALU_FUN_WIDTH(4), .CMD_BYTE(8'hCC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_RX_DATA(rx_data), .i_RX_VALID(rx_valid),
    .o_ALU_A(alu_a), .o_ALU_B(alu_b), .o_ALU_FUN(alu_fun), .o_ALU_EN(alu_en),
    .i_ALU_OUT(alu_out), .i_ALU_VALID(alu_valid),
    .o_TX_DATA(tx_data), .o_TX_VALID(tx_valid), .i_TX_READY(tx_ready),
    .o_BUSY(busy), .o_RX_DROP(rx_drop)
  );

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    logic [15:0] wa, wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (f)
      ALU_ADD:  return wa + wb;
      ALU_SUB:  return wa - wb;
      ALU_MUL:  return wa * wb;
      ALU_DIV:  return (b == 0) ? 16'h0 : wa / wb;
      ALU_AND:  return wa & wb;
      ALU_OR:   return wa | wb;
      ALU_NAND: return {8'h00, ~(a & b)};
      ALU_NOR:  return {8'h00, ~(a | b)};
      ALU_XOR:  return wa ^ wb;
      ALU_XNOR: return {8'h00, ~(a ^ b)};
      ALU_EQ:   return (a == b) ? 16'h1 : 16'h0;
      ALU_GT:   return (a > b) ? 16'h1 : 16'h0;
      ALU_LT:   return (a < b) ? 16'h1 : 16'h0;
      ALU_SHR:  return wa >> 1;
      ALU_SHL:  return wa << 1;
      default:  return 16'h0;
    endcase
  endfunction

  // Registered ALU: result valid one cycle after enable, zero otherwise.
  always @(posedge clk) begin
    if (rst) begin
      alu_out   <= '0;
      alu_valid <= 1'b0;
    end else if (alu_en) begin
      alu_out   <= alu_ref(alu_a, alu_b, alu_fun);
      alu_valid <= 1'b1;
    end else begin
      alu_out   <= '0;
      alu_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (rx_drop) drop_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    send_byte(8'hCC);
    send_byte(a);
    send_byte(b);
    send_byte(f);
  endtask

  task automatic collect_tx(output bit ok);
    int cyc = 0;
    while (tx_q.size() < 2 && cyc < 200) begin
      tick();
      cyc++;
    end
    ok = (tx_q.size() >= 2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({tx_valid, alu_en, busy, rx_drop} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0000", {tx_valid, alu_en, busy, rx_drop});
    end
    checks++;
    if ({alu_a, alu_b, alu_fun, tx_data} !== 28'h0) begin
      errors++; $display("FAIL reset_data got=%h want=0", {alu_a, alu_b, alu_fun, tx_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    tx_q.delete();
    tx_ready = 1'b1;
    send_frame(8'h05, 8'h03, 8'h00);
    @(negedge clk);
    checks++;
    if ({alu_en, alu_a, alu_b, alu_fun} !== {1'b1, 8'h05, 8'h03, 4'h0}) begin
      errors++; $display("FAIL basic_alu_go got=%h want=%h", {alu_en, alu_a, alu_b, alu_fun}, {1'b1, 8'h05, 8'h03, 4'h0});
    end
    @(negedge clk);
    checks++;
    if ({alu_en, tx_valid, busy} !== 3'b001) begin
      errors++; $display("FAIL basic_alu_wait got=%b want=001", {alu_en, tx_valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h08}) begin
      errors++; $display("FAIL basic_lsb_n3 got=%h want=108", {tx_valid, tx_data});
    end
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL basic_msb_n4 got=%h want=100", {tx_valid, tx_data});
    end
    @(negedge clk);
    checks++;
    if ({tx_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL basic_idle_n5 got=%b want=00", {tx_valid, busy});
    end
    checks++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'h08 || tx_q[1] !== 8'h00) begin
      errors++; $display("FAIL basic_bytes got_n=%0d want 08,00", tx_q.size());
    end
    tick();
  endtask

  task automatic test_backpressure();
    int  cyc = 0;
    bit  ok;
    tx_q.delete();
    tx_ready = 1'b0;
    send_frame(8'h0F, 8'h0F, 8'h02);
    @(negedge clk);
    while (!tx_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, 8'hE1}) begin
        errors++; $display("FAIL bp_hold[%0d] got=%h want=1e1", i, {tx_valid, tx_data});
      end
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    collect_tx(ok);
    checks++;
    if (!ok || tx_q[0] !== 8'hE1 || tx_q[1] !== 8'h00) begin
      errors++; $display("FAIL bp_bytes got_n=%0d want e1,00", tx_q.size());
    end
    tick();
  endtask

  task automatic test_leading_junk();
    bit ok;
    tx_q.delete();
    drop_cnt = 0;
    tx_ready = 1'b1;
    send_byte(8'h12);
    send_byte(8'h34);
    tick();
    checks++;
    if (busy !== 1'b0 || drop_cnt != 0) begin
      errors++; $display("FAIL junk_ignored busy=%b drops=%0d want 0,0", busy, drop_cnt);
    end
    send_frame(8'h07, 8'h02, 8'h01);
    collect_tx(ok);
    checks++;
    if (!ok || tx_q[0] !== 8'h05 || tx_q[1] !== 8'h00 || drop_cnt != 0) begin
      errors++; $display("FAIL junk_result n=%0d drops=%0d want 05,00 and 0 drops", tx_q.size(), drop_cnt);
    end
    tick();
  endtask

  task automatic test_drop();
    bit ok;
    tx_q.delete();
    drop_cnt = 0;
    tx_ready = 1'b1;
    send_frame(8'h11, 8'h22, 8'h00);
    tick();
    send_byte(8'h55);
    @(negedge clk);
    checks++;
    if (rx_drop !== 1'b1) begin
      errors++; $display("FAIL drop_pulse got=%b want=1", rx_drop);
    end
    collect_tx(ok);
    repeat (2) tick();
    checks++;
    if (!ok || tx_q[0] !== 8'h33 || tx_q[1] !== 8'h00 || drop_cnt != 1) begin
      errors++; $display("FAIL drop_result n=%0d drops=%0d want 33,00 and 1 drop", tx_q.size(), drop_cnt);
    end
  endtask

  task automatic test_reset_mid_tx();
    int cyc = 0;
    bit ok;
    tx_q.delete();
    tx_ready = 1'b0;
    send_frame(8'h10, 8'h20, 8'h00);
    @(negedge clk);
    while (!tx_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_valid, busy, alu_en, tx_data} !== 11'h0) begin
      errors++; $display("FAIL rst_mid_tx got=%h want=0", {tx_valid, busy, alu_en, tx_data});
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    send_frame(8'h40, 8'h02, 8'h03);
    collect_tx(ok);
    checks++;
    if (!ok || tx_q[0] !== 8'h20 || tx_q[1] !== 8'h00) begin
      errors++; $display("FAIL rst_recover n=%0d want 20,00", tx_q.size());
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0]  a, b, f, j;
    logic [15:0] exp;
    logic        stall;
    logic [7:0]  held;
    int          cyc;
    drop_cnt = 0;
    for (int n = 0; n < 25; n++) begin
      tx_q.delete();
      a = 8'($urandom);
      b = 8'($urandom);
      f = 8'($urandom);
      if (n < 16) f[3:0] = 4'(n);
      exp = alu_ref(a, b, f[3:0]);
      tx_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        j = 8'($urandom);
        if (j == 8'hCC) j = 8'h00;
        send_byte(j);
      end
      send_byte(8'hCC);
      repeat ($urandom_range(0, 2)) tick();
      send_byte(a);
      repeat ($urandom_range(0, 2)) tick();
      send_byte(b);
      repeat ($urandom_range(0, 2)) tick();
      send_byte(f);
      stall = 1'b0;
      held  = '0;
      cyc   = 0;
      while (tx_q.size() < 2 && cyc < 300) begin
        @(negedge clk);
        if (stall) begin
          checks++;
          if (tx_valid !== 1'b1 || tx_data !== held) begin
            errors++; $display("FAIL rand_hold[%0d] got=%b/%h want=1/%h", n, tx_valid, tx_data, held);
          end
        end
        stall = tx_valid && !tx_ready;
        held  = tx_data;
        @(posedge clk); #1;
        tx_ready = 1'($urandom_range(0, 1));
        cyc++;
      end
      checks++;
      if (tx_q.size() != 2 || tx_q[0] !== exp[7:0] || tx_q[1] !== exp[15:8]) begin
        errors++;
        $display("FAIL rand_frame[%0d] a=%h b=%h f=%h got_n=%0d want %h,%h", n, a, b, f, tx_q.size(), exp[7:0], exp[15:8]);
      end
      tx_ready = 1'b0;
      tick();
    end
    checks++;
    if (drop_cnt != 0) begin
      errors++; $display("FAIL rand_drops got=%0d want=0", drop_cnt);
    end
  endtask

`ifdef ALU_CMD_TIMEOUT_EN
  task automatic test_timeout();
    drop_cnt = 0;
    send_byte(8'hCC);
    send_byte(8'h05);
    repeat (TMO - 1) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL tmo_before got=%b want=1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL tmo_expire got=%b want=0", busy);
    end
    send_byte(8'h03);
    tick();
    checks++;
    if (busy !== 1'b0 || drop_cnt != 0) begin
      errors++; $display("FAIL tmo_after busy=%b drops=%0d want 0,0", busy, drop_cnt);
    end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_leading_junk();
    test_drop();
    test_reset_mid_tx();
    test_random();
`ifdef ALU_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
